// File: rtl/vga_pkg.sv
// ============================================================================
//  Module   : vga_pkg
//  Brief    : 640x480@60 timing and colour constants shared by the VGA
//             controller and the pixel generator.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    typedef logic [11:0] rgb444_t;
    typedef logic [9:0]  coord_t;

    // Horizontal timing, in pixel clocks
    localparam coord_t H_SYNC   = 10'd96;
    localparam coord_t H_BACK   = 10'd40;
    localparam coord_t H_LEFT   = 10'd8;
    localparam coord_t H_VALID  = 10'd640;
    localparam coord_t H_RIGHT  = 10'd8;
    localparam coord_t H_FRONT  = 10'd8;
    localparam coord_t H_TOTAL  = 10'd800;

    // Vertical timing, in lines
    localparam coord_t V_SYNC   = 10'd2;
    localparam coord_t V_BACK   = 10'd25;
    localparam coord_t V_TOP    = 10'd8;
    localparam coord_t V_VALID  = 10'd480;
    localparam coord_t V_BOTTOM = 10'd8;
    localparam coord_t V_FRONT  = 10'd2;
    localparam coord_t V_TOTAL  = 10'd525;

    // Active window edges derived from the timing above
    localparam coord_t H_ACT_START = H_SYNC + H_BACK + H_LEFT;
    localparam coord_t H_ACT_END   = H_ACT_START + H_VALID;
    localparam coord_t H_REQ_START = H_ACT_START - 10'd1;
    localparam coord_t H_REQ_END   = H_ACT_END - 10'd1;
    localparam coord_t V_ACT_START = V_SYNC + V_BACK + V_TOP;
    localparam coord_t V_ACT_END   = V_ACT_START + V_VALID;

    localparam coord_t  NO_REQ    = 10'h3FF;

    localparam rgb444_t RGB_BLACK = 12'h000;
    localparam rgb444_t RGB_WHITE = 12'hFFF;
    localparam rgb444_t RGB_RED   = 12'hF00;
    localparam rgb444_t RGB_GREEN = 12'h0F0;
    localparam rgb444_t RGB_BLUE  = 12'h00F;

endpackage

`default_nettype wire

// File: rtl/vga_ctrl.sv
// ============================================================================
//  Module   : vga_ctrl
//  Brief    : 640x480@60 VGA timing generator: H/V counters, sync decode,
//             pixel request one cycle ahead of the active window.
//             Optional frame counter when VGA_CTRL_FRAME_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_ctrl
    import vga_pkg::*;
(
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [11:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
`ifdef VGA_CTRL_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);

    logic [9:0] r_cnt_h;
    logic [9:0] r_cnt_v;
    logic       w_h_end;
    logic       w_v_end;
    logic       w_rgb_valid;
    logic       w_pix_req;

    assign w_h_end = (r_cnt_h == H_TOTAL - 10'd1);
    assign w_v_end = (r_cnt_v == V_TOTAL - 10'd1);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_h <= '0;
        end else if (w_h_end) begin
            r_cnt_h <= '0;
        end else begin
            r_cnt_h <= r_cnt_h + 10'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt_v <= '0;
        end else if (w_h_end) begin
            if (w_v_end) begin
                r_cnt_v <= '0;
            end else begin
                r_cnt_v <= r_cnt_v + 10'd1;
            end
        end
    end

    assign hsync = (r_cnt_h < H_SYNC);
    assign vsync = (r_cnt_v < V_SYNC);

    assign w_rgb_valid = (r_cnt_h >= H_ACT_START) && (r_cnt_h < H_ACT_END) &&
                         (r_cnt_v >= V_ACT_START) && (r_cnt_v < V_ACT_END);

    // Request leads the visible window by one clock to absorb the
    // pixel generator's registered latency.
    assign w_pix_req   = (r_cnt_h >= H_REQ_START) && (r_cnt_h < H_REQ_END) &&
                         (r_cnt_v >= V_ACT_START) && (r_cnt_v < V_ACT_END);

    assign pix_x = w_pix_req ? (r_cnt_h - H_REQ_START) : NO_REQ;
    assign pix_y = w_pix_req ? (r_cnt_v - V_ACT_START) : NO_REQ;

    assign rgb   = w_rgb_valid ? pix_data : RGB_BLACK;

`ifdef VGA_CTRL_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_h_end && w_v_end) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire
